// File: rtl/initer_load_arbiter.sv
// initer_load_arbiter
//   Round-robin arbiter sharing one Initer-style loadable register among NREQ
//   requesters. One load is accepted in IDLE. The winner's value is latched and
//   driven with en for one cycle (LOAD). The winner is then acked for one cycle
//   (ACK). Every output comes straight from a register.
//
//   Optional feature: define INITER_ARB_PRIO_EN to make requester 0 a fixed
//   highest-priority requester. Requesters 1..NREQ-1 then round-robin among
//   themselves, and a grant to requester 0 leaves rr_ptr unchanged.
//
// Ports
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset
//   req      per-requester load request
//   req_val  requester i's value in bits [i*size +: size]
//   val      value to the shared register (held in IDLE)
//   en       load enable to the shared register (LOAD cycle only)
//   ack      one-hot, one-cycle completion pulse (ACK cycle only)
//   gnt_idx  current/last granted requester
//   busy     high in LOAD and ACK
module initer_load_arbiter #(
   parameter int size  = 3,
   parameter int NREQ  = 4,
   parameter int IDX_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*size-1:0] req_val,
   output logic [size-1:0]      val,
   output logic                 en,
   output logic [NREQ-1:0]      ack,
   output logic [IDX_W-1:0]     gnt_idx,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ACK = 2'd2} state_t;

   state_t           state, state_n;
   logic [IDX_W-1:0] rr_ptr, rr_n, gnt_n, win;
   logic [size-1:0]  val_n, win_val;
   logic [NREQ-1:0]  ack_n;
   logic             en_n, busy_n, found;

   // Winner search: rr_ptr, rr_ptr+1, ... wrapping mod NREQ. rr_ptr is always
   // < NREQ, so a single conditional subtract performs the wrap.
   always_comb begin
      logic [NREQ-1:0] cand_req;
      logic [IDX_W:0]  cand;
      found    = 1'b0;
      win      = '0;
      cand     = '0;
      cand_req = req;
`ifdef INITER_ARB_PRIO_EN
      if (req[0]) begin
         found = 1'b1;
         win   = '0;
      end
      cand_req[0] = 1'b0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (cand >= (IDX_W+1)'(NREQ))
            cand = cand - (IDX_W+1)'(NREQ);
         if (!found && cand_req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            win   = cand[IDX_W-1:0];
         end
      end
   end

   // Value mux for the winner
   always_comb begin
      win_val = '0;
      for (int i = 0; i < NREQ; i++)
         if (win == IDX_W'(i))
            win_val = req_val[i*size +: size];
   end

   // Next state and next registered outputs
   always_comb begin
      state_n = state;
      val_n   = val;
      en_n    = 1'b0;
      ack_n   = '0;
      gnt_n   = gnt_idx;
      busy_n  = 1'b0;
      rr_n    = rr_ptr;
      case (state)
         IDLE: begin
            if (found) begin
               gnt_n   = win;
               val_n   = win_val;
               en_n    = 1'b1;
               busy_n  = 1'b1;
               state_n = LOAD;
            end
         end
         LOAD: begin
            busy_n  = 1'b1;
            state_n = ACK;
            for (int i = 0; i < NREQ; i++)
               ack_n[i] = (gnt_idx == IDX_W'(i));
         end
         ACK: begin
            state_n = IDLE;
`ifdef INITER_ARB_PRIO_EN
            // the fixed-priority requester does not advance the rotation
            if (gnt_idx != '0)
`endif
               rr_n = (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + IDX_W'(1);
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         val     <= '0;
         en      <= 1'b0;
         ack     <= '0;
         gnt_idx <= '0;
         busy    <= 1'b0;
         rr_ptr  <= '0;
      end else begin
         state   <= state_n;
         val     <= val_n;
         en      <= en_n;
         ack     <= ack_n;
         gnt_idx <= gnt_n;
         busy    <= busy_n;
         rr_ptr  <= rr_n;
      end
   end

endmodule

// File: tb/tb_initer_load_arbiter.sv
module tb_initer_load_arbiter;
   localparam int SIZE  = 3;
   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*SIZE-1:0] req_val = '0;
   logic [SIZE-1:0]      val;
   logic                 en;
   logic [NREQ-1:0]      ack;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 busy;

   initer_load_arbiter #(.size(SIZE), .NREQ(NREQ), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_val(req_val),
      .val(val), .en(en), .ack(ack), .gnt_idx(gnt_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   // shared register fed by the arbiter
   logic [SIZE-1:0] shreg = '0;
   always @(posedge clk) if (en) shreg <= val;

   int checks = 0;
   int errors = 0;

   // Transaction-level reference: a grant happens on edge g_edge, en is seen
   // after g_edge, ack after g_edge+1, and the next sample is edge g_edge+3.
   int              n_edge = 0;
   int              g_edge = -100;
   int              m_rr   = 0;
   int              m_gnt  = 0;
   logic [SIZE-1:0] m_val  = '0;
   logic [SIZE-1:0] m_reg  = '0;

   function automatic int pick(logic [NREQ-1:0] r, int rr);
`ifdef INITER_ARB_PRIO_EN
      if (r[0]) return 0;
      r[0] = 1'b0;
`endif
      for (int k = 0; k < NREQ; k++)
         if (r[(rr + k) % NREQ]) return (rr + k) % NREQ;
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] exp_ack;
      logic            exp_en;
      @(posedge clk);
      n_edge++;
      if (n_edge == g_edge + 1) m_reg = m_val;  // register captured during LOAD
      if (rst) begin
         g_edge = -100;
         m_rr   = 0;
         m_gnt  = 0;
         m_val  = '0;
      end else if (n_edge >= g_edge + 3 && req != '0) begin
         m_gnt  = pick(req, m_rr);
         m_val  = req_val[m_gnt*SIZE +: SIZE];
         g_edge = n_edge;
`ifdef INITER_ARB_PRIO_EN
         if (m_gnt != 0)
`endif
            m_rr = (m_gnt + 1) % NREQ;
      end
      @(negedge clk);
      exp_en  = (n_edge == g_edge);
      exp_ack = '0;
      if (n_edge == g_edge + 1) exp_ack[m_gnt] = 1'b1;
      chk("en",      32'(en),      32'(exp_en));
      chk("ack",     32'(ack),     32'(exp_ack));
      chk("busy",    32'(busy),    32'(exp_en || (exp_ack != '0)));
      chk("gnt_idx", 32'(gnt_idx), 32'(m_gnt));
      chk("val",     32'(val),     32'(m_val));
      chk("shreg",   32'(shreg),   32'(m_reg));
   endtask

   int order[4];
   int ack_edge[4];
   int nack;
   logic [SIZE-1:0] orig;

   initial begin
      // reset with everyone requesting
      rst = 1'b1; req = 4'b1111; req_val = 12'($urandom);
      step(); step();
      chk("rst_en", 32'(en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_val", 32'(val), 0);

      // all requesting, each drops after its ack
      rst = 1'b0;
      step();
      chk("first_grant", 32'(gnt_idx), 0);
      nack = 0;
      for (int c = 0; c < 20 && nack < 4; c++) begin
         step();
         for (int i = 0; i < NREQ; i++)
            if (ack[i] && nack < 4) begin
               order[nack] = i; ack_edge[nack] = n_edge; nack++; req[i] = 1'b0;
            end
      end
      chk("allreq_count", 32'(nack), 4);
      for (int i = 0; i < 4; i++) begin
         chk("allreq_order", 32'(order[i]), 32'(i));
         if (i > 0) chk("allreq_spacing", 32'(ack_edge[i] - ack_edge[i-1]), 3);
      end
      step(); step();

      // single request from requester 2
      req = 4'b0100; req_val = 12'($urandom); req_val[2*SIZE +: SIZE] = 3'b101;
      step();
      chk("single_en", 32'(en), 1);
      chk("single_val", 32'(val), 5);
      step();
      chk("single_ack", 32'(ack), 32'h4);
      req = '0;
      step();
      chk("single_en_off", 32'(en), 0);
      chk("single_ack_off", 32'(ack), 0);
      chk("single_reg", 32'(shreg), 5);
      step();

      // wrap: rotation now points at 3
      req = 4'b1001; req_val = 12'($urandom);
      step();
`ifdef INITER_ARB_PRIO_EN
      chk("wrap_first", 32'(gnt_idx), 0);
`else
      chk("wrap_first", 32'(gnt_idx), 3);
`endif
      step();
      for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
      step(); step();
`ifdef INITER_ARB_PRIO_EN
      chk("wrap_second", 32'(gnt_idx), 3);
`else
      chk("wrap_second", 32'(gnt_idx), 0);
`endif
      step();
      req = '0;
      step(); step();

      // change req/req_val during LOAD
      req = 4'b0010; req_val = 12'($urandom);
      orig = req_val[SIZE +: SIZE];
      step();
      req = '0; req_val = ~req_val;
      step();
      chk("midop_ack", 32'(ack), 32'h2);
      chk("midop_val", 32'(val), 32'(orig));
      step();
      chk("midop_reg", 32'(shreg), 32'(orig));
      step();

      // reset during LOAD, request re-served afterwards
      req = 4'b1000; req_val = 12'($urandom);
      step();
      rst = 1'b1;
      step();
      chk("rstmid_en", 32'(en), 0);
      chk("rstmid_ack", 32'(ack), 0);
      rst = 1'b0;
      step();
      chk("rstmid_regrant", 32'(gnt_idx), 3);
      chk("rstmid_regrant_en", 32'(en), 1);
      step();
      req = '0;
      step(); step();

      // randomized traffic against the reference
      for (int c = 0; c < 400; c++) begin
         rst     = ($urandom_range(0, 39) == 0);
         req     = 4'($urandom & $urandom);
         req_val = 12'($urandom);
         step();
      end
      rst = 1'b0; req = '0;
      step(); step(); step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
